msg_stream_gen: RTL
===================

# msg_stream_gen

Parametrised character-message streamer, successor to the fixed single-string display generator. Holds `NUM_MSG` runtime-writable messages of up to `MAX_LEN` characters. On `start` it streams the selected message one character per accepted beat to the display write port, honouring sink backpressure. It optionally repeats with a programmable inter-message gap, and supports abort.

## Interface
- `DATA_W`, 8: character width in bits.
- `MAX_LEN`, 16: maximum characters per message; must be ≥1.
- `NUM_MSG`, 4: number of stored messages; must be ≥1.
- `GAP_CYC`, 0: idle cycles between repeats; 0 means back-to-back.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin streaming; sampled only in IDLE.
- `msg_sel`  in  `MSW=max(1,$clog2(NUM_MSG))`  message index, latched with `start`.
- `repeat_en`  in  1  loop the message until abort; latched with `start`.
- `abort`  in  1  terminate streaming.
- `cfg_we`  in  1  write one character.
- `cfg_len_we`  in  1  write one message length.
- `cfg_msg`  in  `MSW`  message addressed by the config port.
- `cfg_idx`  in  `$clog2(MAX_LEN)`  character index for the write.
- `cfg_data`  in  `DATA_W`  character value.
- `cfg_len`  in  `LW=$clog2(MAX_LEN+1)`  length value.
- `ready`  in  1  sink accepts the current beat.
- `data`  out  `DATA_W`  current character; 0 when `wen`=0.
- `wen`  out  1  beat valid.
- `busy`  out  1  high in every state other than IDLE.
- `done`  out  1  one-cycle pulse at normal completion.

## Operation
- States:
  - IDLE: `start` → SEND with index 0 when the latched length is >0.
  - SEND: on an accepted beat (`wen && ready`) at `index == len-1`:
    - latched `repeat_en`=1 and `GAP_CYC`>0 → GAP;
    - latched `repeat_en`=1 and `GAP_CYC`=0 → SEND, index 0;
    - otherwise → IDLE, with `done` asserted in that first IDLE cycle.
    - An accepted beat at any other index increments the index.
  - GAP: counts `GAP_CYC` cycles, then → SEND, index 0.
- `wen`=1 exactly in SEND. `data` = store[msg][index]. Both are derived from registers only; there is no `ready`→`wen` combinational path.
- While `wen && !ready`, `data` and `wen` are held stable.
- A zero-length message at `start` produces no beats; `done` pulses the next cycle regardless of `repeat_en`.
- `abort` has priority over everything except `reset`. From any state, the next state is IDLE, with no `done` and no further beats. An `abort` in IDLE is a no-op. An `abort` together with `start` in IDLE: `abort` wins.
- `start` outside IDLE is ignored. `msg_sel` and `repeat_en` have no effect except when sampled with `start`.
- Config writes are accepted only when `busy`=0 and dropped silently otherwise. `cfg_len` > `MAX_LEN` is clamped to `MAX_LEN`. `cfg_idx` ≥ `MAX_LEN` is dropped. `cfg_we` and `cfg_len_we` in the same cycle are both performed.

## Timing
- Reset values: state IDLE; `data`=0, `wen`=0, `busy`=0, `done`=0; all lengths 0; index and gap counter 0. Character storage is not reset.
- Latency: `start` sampled at edge N → `wen`=1 with char 0 in cycle N+1.
- Throughput: 1 char/cycle with `ready` held high.
- A message of L characters under continuous `ready` completes with `done` high in cycle N+L+1.
- Repeat with `GAP_CYC`=G: G cycles of `wen`=0 between the last beat and the next char 0.
- A config write at edge N is visible to a `start` sampled at edge N+1.

## Structure
- Package `msg_stream_pkg`: state enum (IDLE, SEND, GAP) and the width helper functions for `MSW` and `LW`.
- Sub-module `msg_store`: `NUM_MSG×MAX_LEN×DATA_W` character array plus the length array. It has the write port, clamping, and one asynchronous read port addressed by (msg, index).
- Top level: FSM, index and gap counters, latched control.

## Test plan
- Load msg 1 = "ZAG" (90, 65, 71), length 3; `start` with `ready`=1 → beats 90, 65, 71 on three consecutive cycles, then `done` for one cycle, then `busy`=0.
- Same message with `ready` low for 2 cycles on beat 65 → 65 held for 3 cycles, no duplicates or drops, `done` delayed by 2 cycles.
- `GAP_CYC`=2, `repeat_en`=1 → 90, 65, 71, two idle cycles, 90, …; `abort` mid-stream → `wen`=0 next cycle, no `done`.
- Length 0 message with `repeat_en`=1 → no `wen`, `done` 1 cycle after `start`. `cfg_len`=20 with `MAX_LEN`=16 → stored length 16.
- Config write to the active message while busy → ignored; the streamed output is unchanged. `start` while busy → ignored.
- `reset` asserted mid-stream → all outputs 0 the following cycle and lengths cleared; a later `start` → immediate `done`.

Source files
------------

// File: rtl/msg_stream_pkg.sv
// Shared types and width helpers for the message streamer.
package msg_stream_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  function automatic int msw_calc(input int num_msg);
    return (num_msg > 1) ? $clog2(num_msg) : 1;
  endfunction

  function automatic int lw_calc(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int iw_calc(input int max_len);
    return (max_len > 1) ? $clog2(max_len) : 1;
  endfunction

  function automatic int gw_calc(input int gap_cyc);
    return (gap_cyc > 0) ? $clog2(gap_cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/msg_stream_gen_if.sv
// Display write port: one character per beat, sink backpressure on ready.
interface msg_stream_gen_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] data;
  logic              wen;
  logic              ready;

  modport master (output data, output wen, input ready);
  modport slave  (input data, input wen, output ready);
endinterface

// File: rtl/msg_store.sv
// Character and length storage for all messages; write port gated by the
// caller, asynchronous reads.
module msg_store
  import msg_stream_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int NUM_MSG = 4,
  localparam int MSW = msw_calc(NUM_MSG),
  localparam int LW  = lw_calc(MAX_LEN),
  localparam int IW  = iw_calc(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_allow,
  input  logic              cfg_we,
  input  logic              cfg_len_we,
  input  logic [MSW-1:0]    cfg_msg,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [LW-1:0]     cfg_len,
  input  logic [MSW-1:0]    len_msg,
  output logic [LW-1:0]     len_out,
  input  logic [MSW-1:0]    rd_msg,
  input  logic [IW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_char
);

  logic [DATA_W-1:0]         char_mem [NUM_MSG][MAX_LEN];
  logic [NUM_MSG-1:0][LW-1:0] len_mem;
  logic                      msg_ok;
  logic                      idx_ok;
  logic [LW-1:0]             len_clamped;

  assign msg_ok      = int'(cfg_msg) < NUM_MSG;
  assign idx_ok      = int'(cfg_idx) < MAX_LEN;
  assign len_clamped = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;

  // Character contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_allow && cfg_we && msg_ok && idx_ok) begin
      char_mem[cfg_msg][cfg_idx] <= cfg_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MSG; gi++) begin : g_len
      logic [LW-1:0] len_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          len_q <= '0;
        end else if (wr_allow && cfg_len_we && (int'(cfg_msg) == gi)) begin
          len_q <= len_clamped;
        end
      end

      assign len_mem[gi] = len_q;
    end
  endgenerate

  assign len_out = (int'(len_msg) < NUM_MSG) ? len_mem[len_msg] : '0;
  assign rd_char = char_mem[rd_msg][rd_idx];

endmodule

// File: rtl/msg_stream_gen.sv
// Streams a stored message one character per accepted beat, with optional
// repeat, inter-message gap and abort.
module msg_stream_gen
  import msg_stream_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 16,
  parameter int NUM_MSG = 4,
  parameter int GAP_CYC = 0,
  localparam int MSW = msw_calc(NUM_MSG),
  localparam int LW  = lw_calc(MAX_LEN),
  localparam int IW  = iw_calc(MAX_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MSW-1:0]    msg_sel,
  input  logic              repeat_en,
  input  logic              abort,
  input  logic              cfg_we,
  input  logic              cfg_len_we,
  input  logic [MSW-1:0]    cfg_msg,
  input  logic [IW-1:0]     cfg_idx,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [LW-1:0]     cfg_len,
  msg_stream_gen_if.master  disp,
  output logic              busy,
  output logic              done
);

  localparam int GW = gw_calc(GAP_CYC);

  state_t         state_reg, state_next;
  logic [MSW-1:0] msg_reg, msg_next;
  logic           rep_reg, rep_next;
  logic [LW-1:0]  len_reg, len_next;
  logic [IW-1:0]  idx_reg, idx_next;
  logic [GW-1:0]  gap_reg, gap_next;
  logic           done_reg, done_next;

  logic [LW-1:0]     sel_len;
  logic [DATA_W-1:0] rd_char;
  logic              last_beat;
  logic              gap_end;

  msg_store #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN),
    .NUM_MSG (NUM_MSG)
  ) u_store (
    .clk        (clk),
    .reset      (reset),
    .wr_allow   (!busy),
    .cfg_we     (cfg_we),
    .cfg_len_we (cfg_len_we),
    .cfg_msg    (cfg_msg),
    .cfg_idx    (cfg_idx),
    .cfg_data   (cfg_data),
    .cfg_len    (cfg_len),
    .len_msg    (msg_sel),
    .len_out    (sel_len),
    .rd_msg     (msg_reg),
    .rd_idx     (idx_reg),
    .rd_char    (rd_char)
  );

  // Length is latched at start so the stream is immune to later edits.
  assign last_beat = (LW'(idx_reg) + LW'(1)) == len_reg;
  assign gap_end   = int'(gap_reg) == (GAP_CYC - 1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      msg_reg   <= '0;
      rep_reg   <= 1'b0;
      len_reg   <= '0;
      idx_reg   <= '0;
      gap_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      msg_reg   <= msg_next;
      rep_reg   <= rep_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      gap_reg   <= gap_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    msg_next   = msg_reg;
    rep_next   = rep_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    gap_next   = gap_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!abort && start) begin
          msg_next = msg_sel;
          rep_next = repeat_en;
          len_next = sel_len;
          idx_next = '0;
          if (sel_len != '0) begin
            state_next = SEND;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      SEND: begin
        if (abort) begin
          state_next = IDLE;
        end else if (disp.ready) begin
          if (last_beat) begin
            idx_next = '0;
            if (!rep_reg) begin
              state_next = IDLE;
              done_next  = 1'b1;
            end else if (GAP_CYC > 0) begin
              state_next = GAP;
              gap_next   = '0;
            end
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end

      GAP: begin
        if (abort) begin
          state_next = IDLE;
        end else if (gap_end) begin
          state_next = SEND;
          idx_next   = '0;
          gap_next   = '0;
        end else begin
          gap_next = gap_reg + GW'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign busy      = state_reg != IDLE;
  assign done      = done_reg;
  assign disp.wen  = state_reg == SEND;
  assign disp.data = disp.wen ? rd_char : '0;

endmodule
